shift_reg_chain: RTL and testbench
==================================

# shift_reg_chain

Parametrised multi-stage shift register for the systolic datapath. It succeeds the single-stage 8-bit load/shift cell. It chains DEPTH stages of WIDTH bits, each with a valid bit, and supports parallel load of all stages, enabled shifting and hold. It tracks occupancy so operand feeders can tell when the chain is full or drained. An optional rotate mode recirculates the last stage into the first for operand reuse.

## Interface
- WIDTH, 8, data width per stage in bits (>= 1)
- DEPTH, 4, number of stages (>= 2)
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  parallel-load all stages from pload
- pload  in  DEPTH*WIDTH  load data; stage i takes pload[i*WIDTH +: WIDTH]
- shift_en  in  1  advance the chain by one stage
- shin  in  WIDTH  serial data into stage 0
- shin_valid  in  1  valid flag accompanying shin
- rotate  in  1  recirculate the chain; present only with SHIFTREG_ROTATE_EN
- out  out  WIDTH  stage DEPTH-1 data
- out_valid  out  1  stage DEPTH-1 valid bit
- stages  out  DEPTH*WIDTH  all stage data, same packing as pload
- count  out  $clog2(DEPTH+1)  number of valid stages
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- State: stage[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], count register.
- Per-cycle priority: reset > load > rotate > shift_en > hold.
- reset: all stages, vld and count go to 0.
- load: stage[i] <= pload slice i for all i; all vld set to 1; count <= DEPTH. shift_en and rotate are ignored that cycle.
- rotate (macro only): stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1] for i > 0. vld rotates identically. count is unchanged.
- shift_en: stage[0] <= shin and vld[0] <= shin_valid. stage[i] <= stage[i-1] and vld[i] <= vld[i-1].
  - The stage[DEPTH-1] contents are discarded.
  - count <= count + shin_valid - vld[DEPTH-1].
  - shin data is captured even when shin_valid=0; only the valid bit marks the bubble.
- Hold (no command): all state retained.
- count must always equal the popcount of vld. A mismatch is a bench assertion failure.
- full and empty are combinational decodes of count.

## Timing
- All outputs are driven directly from registers or from decodes of count. There is no combinational input-to-output path.
- Reset values: out=0, out_valid=0, stages=0, count=0, full=0, empty=1.
- Shift latency: shin presented with shift_en in cycle N appears on out after DEPTH shifting edges. Hold cycles in between add delay.
- Load latency: stages and out reflect pload one edge after load=1.
- Shift while full with shin_valid=1: count stays DEPTH and the oldest entry leaves via out.
- Shift while empty with shin_valid=0: count stays 0 and no underflow occurs.
- Reset asserted mid-shift or mid-load clears all state at that edge. Commands in the same cycle are ignored.

## Configuration
- SHIFTREG_ROTATE_EN defined:
  - The rotate port exists and the rotate mode is active at the priority given above.
- SHIFTREG_ROTATE_EN undefined:
  - The rotate port is absent.
  - The chain supports only load, shift and hold.
  - There is no recirculation logic.

## Test plan
All scenarios use WIDTH=8 and DEPTH=4.
- Reset: assert reset for 2 cycles -> out=0x00, out_valid=0, count=0, empty=1, full=0.
- Fill: shift in 0x11, 0x22, 0x33, 0x44, all valid, on consecutive cycles.
  - After the 4th edge: out=0x11, out_valid=1, count=4, full=1.
  - A 5th shift of 0x55: out=0x22, count=4.
- Load priority: load=1, shift_en=1, pload={0x04,0x03,0x02,0x01} -> stages s0..s3 = 0x01..0x04, out=0x04, count=4. shin is not captured.
- Drain with bubbles: from full, 4 shifts with shin_valid=0.
  - count goes 3, 2, 1, 0.
  - empty=1 after the 4th shift.
  - out_valid goes 0 on the 4th shift.
- Hold and reset mid-operation:
  - shift_en=0 for 10 cycles -> stages unchanged.
  - Then reset with shift_en=1 -> all zero and count=0 the next cycle.
- Rotate (SHIFTREG_ROTATE_EN): after loading 0x01..0x04, rotate 4 times.
  - out goes 0x03, 0x02, 0x01, 0x04.
  - count stays 4 throughout.
  - The original stages are restored after the 4th rotate.

Source files
------------

// File: rtl/shift_reg_chain_if.sv
// shift_reg_chain_if: command and observation bundle for the shift_reg_chain.
// The master side (operand feeder) drives load/shift commands and reads the
// chain state.  The slave side is the chain itself.
// The rotate command exists only when SHIFTREG_ROTATE_EN is defined.
interface shift_reg_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     load;
    logic [DEPTH*WIDTH-1:0]   pload;
    logic                     shift_en;
    logic [WIDTH-1:0]         shin;
    logic                     shin_valid;
`ifdef SHIFTREG_ROTATE_EN
    logic                     rotate;
`endif
    logic [WIDTH-1:0]         out;
    logic                     out_valid;
    logic [DEPTH*WIDTH-1:0]   stages;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;

`ifdef SHIFTREG_ROTATE_EN
    modport master (
        output load, pload, shift_en, shin, shin_valid, rotate,
        input  out, out_valid, stages, count, full, empty
    );

    modport slave (
        input  load, pload, shift_en, shin, shin_valid, rotate,
        output out, out_valid, stages, count, full, empty
    );
`else
    modport master (
        output load, pload, shift_en, shin, shin_valid,
        input  out, out_valid, stages, count, full, empty
    );

    modport slave (
        input  load, pload, shift_en, shin, shin_valid,
        output out, out_valid, stages, count, full, empty
    );
`endif
endinterface

// File: rtl/shift_reg_chain.sv
// shift_reg_chain: DEPTH stages of WIDTH-bit data, each with a valid bit.
// Supports parallel load, enabled shift and hold, and keeps an occupancy
// count so feeders can see when the chain is full or drained.
// Optional macro SHIFTREG_ROTATE_EN adds a rotate command that feeds the
// last stage back into stage 0 for operand reuse.
// Command priority each cycle: reset > load > rotate > shift_en > hold.
module shift_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    shift_reg_chain_if.slave   bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0]       stage_q [DEPTH];
    logic [DEPTH-1:0]       vld_q;
    logic [CW-1:0]          count_q;
    logic [DEPTH*WIDTH-1:0] stages_flat;

    // Chain state update; count moves by shin_valid in and the last valid out,
    // so it stays equal to the popcount of vld_q without recounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else if (bus.load) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= bus.pload[i*WIDTH +: WIDTH];
            end
            vld_q   <= '1;
            count_q <= DEPTH_C;
        end
`ifdef SHIFTREG_ROTATE_EN
        else if (bus.rotate) begin
            stage_q[0] <= stage_q[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            vld_q <= {vld_q[DEPTH-2:0], vld_q[DEPTH-1]};
        end
`endif
        else if (bus.shift_en) begin
            stage_q[0] <= bus.shin;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            vld_q   <= {vld_q[DEPTH-2:0], bus.shin_valid};
            count_q <= count_q + CW'(bus.shin_valid) - CW'(vld_q[DEPTH-1]);
        end
    end

    // Pack the stage array into the flat bus, stage i at slice i.
    always_comb begin
        stages_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stages_flat[i*WIDTH +: WIDTH] = stage_q[i];
        end
    end

    assign bus.out       = stage_q[DEPTH-1];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.stages    = stages_flat;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == DEPTH_C);
    assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_shift_reg_chain.sv
// tb_shift_reg_chain: directed test of shift_reg_chain at WIDTH=8, DEPTH=4.
// Expected values are hand-computed; rotate checks are built only when
// SHIFTREG_ROTATE_EN is defined.
module tb_shift_reg_chain;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    shift_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    shift_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of commands, clock it, then settle just after the edge.
    task automatic applyStimulus(input logic ld, input logic [31:0] pl,
                                 input logic sh, input logic [7:0] si,
                                 input logic sv);
        bus.load       = ld;
        bus.pload      = pl;
        bus.shift_en   = sh;
        bus.shin       = si;
        bus.shin_valid = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [31:0] st,
                              input logic [2:0] cnt, input logic ov);
        checkOutput({tag, ".stages"}, bus.stages, st);
        checkOutput({tag, ".out"}, {24'h0, bus.out}, {24'h0, st[31:24]});
        checkOutput({tag, ".count"}, {29'h0, bus.count}, {29'h0, cnt});
        checkOutput({tag, ".out_valid"}, {31'h0, bus.out_valid}, {31'h0, ov});
        checkOutput({tag, ".full"}, {31'h0, bus.full}, {31'h0, (cnt == 3'd4)});
        checkOutput({tag, ".empty"}, {31'h0, bus.empty}, {31'h0, (cnt == 3'd0)});
    endtask

`ifdef SHIFTREG_ROTATE_EN
    task automatic rotateStep(input logic sh);
        bus.rotate = 1'b1;
        applyStimulus(1'b0, 32'h0, sh, 8'hCC, 1'b1);
        bus.rotate = 1'b0;
    endtask
`endif

    // Directed scenario sequence.
    initial begin
        assert_count = 0;
        fail_count   = 0;
`ifdef SHIFTREG_ROTATE_EN
        bus.rotate = 1'b0;
`endif
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        checkState("reset", 32'h0000_0000, 3'd0, 1'b0);
        reset = 1'b0;

        // Fill with four valid entries.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h11, 1'b1);
        checkState("fill1", 32'h0000_0011, 3'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h22, 1'b1);
        checkState("fill2", 32'h0000_1122, 3'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h33, 1'b1);
        checkState("fill3", 32'h0011_2233, 3'd3, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h44, 1'b1);
        checkState("fill4", 32'h1122_3344, 3'd4, 1'b1);

        // Shift while full: oldest leaves, count stays at DEPTH.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h55, 1'b1);
        checkState("fill5", 32'h2233_4455, 3'd4, 1'b1);

        // Load wins over shift; shin must not be captured.
        applyStimulus(1'b1, 32'h0403_0201, 1'b1, 8'hAA, 1'b1);
        checkState("load", 32'h0403_0201, 3'd4, 1'b1);

        // Drain with bubbles; bubble data is still captured.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'hE1, 1'b0);
        checkState("drain1", 32'h0302_01E1, 3'd3, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'hE2, 1'b0);
        checkState("drain2", 32'h0201_E1E2, 3'd2, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'hE3, 1'b0);
        checkState("drain3", 32'h01E1_E2E3, 3'd1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 8'hE4, 1'b0);
        checkState("drain4", 32'hE1E2_E3E4, 3'd0, 1'b0);

        // Shift while empty with a bubble: no underflow.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'hE5, 1'b0);
        checkState("empty_shift", 32'hE2E3_E4E5, 3'd0, 1'b0);

        // One valid entry, then hold for ten cycles.
        applyStimulus(1'b0, 32'h0, 1'b1, 8'h5A, 1'b1);
        checkState("one_valid", 32'hE3E4_E55A, 3'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h99, 1'b1);
            checkOutput("hold.stages", bus.stages, 32'hE3E4_E55A);
            checkOutput("hold.count", {29'h0, bus.count}, 32'd1);
        end

        // Reset with commands present clears everything at that edge.
        reset = 1'b1;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 8'h77, 1'b1);
        checkState("reset_mid", 32'h0000_0000, 3'd0, 1'b0);
        reset = 1'b0;

`ifdef SHIFTREG_ROTATE_EN
        applyStimulus(1'b1, 32'h0403_0201, 1'b0, 8'h00, 1'b0);
        checkState("rot_load", 32'h0403_0201, 3'd4, 1'b1);
        rotateStep(1'b1);
        checkState("rot1", 32'h0302_0104, 3'd4, 1'b1);
        rotateStep(1'b0);
        checkState("rot2", 32'h0201_0403, 3'd4, 1'b1);
        rotateStep(1'b0);
        checkState("rot3", 32'h0104_0302, 3'd4, 1'b1);
        rotateStep(1'b0);
        checkState("rot4", 32'h0403_0201, 3'd4, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
